// File: rtl/sort_pkg.sv
// Shared types and constants for the sort engine stream adapter.
package sort_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [AW-1:0]    addr_t;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    UNLOAD
  } adapter_state_t;

  localparam addr_t LAST_IDX = addr_t'(DEPTH - 1);

endpackage

// File: rtl/sort_stream_adapter_if.sv
// Valid/ready input and output byte streams of the sort adapter.
interface sort_stream_adapter_if;

  logic            in_valid;
  logic            in_ready;
  sort_pkg::data_t in_data;
  logic            out_valid;
  logic            out_ready;
  sort_pkg::data_t out_data;
  logic            out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sort_out_reg.sv
// Output holding register: captures the sorter's registered read data one
// cycle after a read is issued and holds it until the downstream accepts.
module sort_out_reg
  import sort_pkg::*;
(
  input  logic  clk,
  input  logic  nrst,
  input  logic  i_issue,
  input  logic  i_issue_last,
  input  data_t i_rd_data,
  input  logic  i_out_ready,
  output logic  o_valid,
  output logic  o_last,
  output data_t o_data,
  output logic  o_can_issue_c
);

  logic  r_rd_pend;
  logic  r_pend_last;
  logic  r_valid;
  logic  r_last;
  data_t r_data;

  // A new read may go out only when nothing is in flight and the holding slot frees up this cycle.
  assign o_can_issue_c = !r_rd_pend && (!r_valid || i_out_ready);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_pend   <= 1'b0;
      r_pend_last <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= '0;
    end else begin
      r_rd_pend <= i_issue;
      if (i_issue) begin
        r_pend_last <= i_issue_last;
      end
      if (r_rd_pend) begin
        r_valid <= 1'b1;
        r_last  <= r_pend_last;
        r_data  <= i_rd_data;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/sort_stream_adapter.sv
// Streams an 8-byte frame into the selection-sort engine, starts it, and
// streams the sorted bytes back out lowest address first.
module sort_stream_adapter
  import sort_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  sort_stream_adapter_if.slave  io_bus,
  output logic                  o_busy,
  output data_t                 o_srt_datain_c,
  output addr_t                 o_srt_addr_c,
  output logic                  o_srt_wr_c,
  output logic                  o_srt_start_c,
  input  logic                  i_srt_ready,
  input  data_t                 i_srt_dataout
);

  adapter_state_t r_state, w_nxt_state;
  addr_t          r_cnt, w_nxt_cnt;
  logic           r_seen_busy, w_nxt_seen_busy;
  logic           r_rd_done, w_nxt_rd_done;
  logic           r_in_ready;
  logic           r_busy;

  logic w_wr;
  logic w_start;
  logic w_issue;
  logic w_can_issue;
  logic w_out_valid;
  logic w_out_last;

  // State and counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_seen_busy <= 1'b0;
      r_rd_done   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_seen_busy <= w_nxt_seen_busy;
      r_rd_done   <= w_nxt_rd_done;
      r_in_ready  <= (w_nxt_state == LOAD);
      r_busy      <= (w_nxt_state != LOAD);
    end
  end

  // Next-state and sorter host-port strobes.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_seen_busy = r_seen_busy;
    w_nxt_rd_done   = r_rd_done;
    w_wr            = 1'b0;
    w_start         = 1'b0;
    w_issue         = 1'b0;
    case (r_state)
      LOAD: begin
        if (io_bus.in_valid && r_in_ready) begin
          w_wr      = 1'b1;
          w_nxt_cnt = r_cnt + AW'(1);
          if (r_cnt == LAST_IDX) begin
            w_nxt_state = START;
            w_nxt_cnt   = '0;
          end
        end
      end
      START: begin
        if (i_srt_ready) begin
          w_start     = 1'b1;
          w_nxt_state = WAIT;
        end
      end
      WAIT: begin
        // Ready left over from before the start is ignored until busy has been seen.
        if (r_seen_busy && i_srt_ready) begin
          w_nxt_state     = UNLOAD;
          w_nxt_seen_busy = 1'b0;
        end else if (!i_srt_ready) begin
          w_nxt_seen_busy = 1'b1;
        end
      end
      UNLOAD: begin
        if (w_can_issue && !r_rd_done) begin
          w_issue   = 1'b1;
          w_nxt_cnt = r_cnt + AW'(1);
          if (r_cnt == LAST_IDX) begin
            w_nxt_rd_done = 1'b1;
          end
        end
        if (w_out_valid && w_out_last && io_bus.out_ready) begin
          w_nxt_state   = LOAD;
          w_nxt_cnt     = '0;
          w_nxt_rd_done = 1'b0;
        end
      end
      default: begin
        w_nxt_state = LOAD;
      end
    endcase
  end

  sort_out_reg u_out_reg (
    .clk           (clk),
    .nrst          (nrst),
    .i_issue       (w_issue),
    .i_issue_last  (r_cnt == LAST_IDX),
    .i_rd_data     (i_srt_dataout),
    .i_out_ready   (io_bus.out_ready),
    .o_valid       (w_out_valid),
    .o_last        (w_out_last),
    .o_data        (io_bus.out_data),
    .o_can_issue_c (w_can_issue)
  );

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_last  = w_out_last;
  assign o_busy           = r_busy;

  assign o_srt_wr_c     = w_wr;
  assign o_srt_start_c  = w_start;
  assign o_srt_datain_c = w_wr ? io_bus.in_data : '0;
  assign o_srt_addr_c   = (r_state == LOAD || r_state == UNLOAD) ? r_cnt : '0;

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Directed bench for sort_stream_adapter with a behavioural sorter and an output scoreboard.
module tb_sort_stream_adapter;
  import sort_pkg::*;

  typedef logic [7:0][7:0] frame_t;
  typedef struct packed {
    data_t d;
    logic  l;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b1;

  sort_stream_adapter_if bus ();

  logic  w_busy;
  data_t w_srt_datain;
  addr_t w_srt_addr;
  logic  w_srt_wr;
  logic  w_srt_start;
  logic  s_ready;
  data_t s_dout;

  sort_stream_adapter dut (
    .clk            (clk),
    .nrst           (nrst),
    .io_bus         (bus),
    .o_busy         (w_busy),
    .o_srt_datain_c (w_srt_datain),
    .o_srt_addr_c   (w_srt_addr),
    .o_srt_wr_c     (w_srt_wr),
    .o_srt_start_c  (w_srt_start),
    .i_srt_ready    (s_ready),
    .i_srt_dataout  (s_dout)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t q[$];
  logic rnd_mode    = 1'b0;
  int   s_stale     = 0;
  int   s_busy_len  = 4;

  function automatic frame_t sort8(input frame_t a);
    frame_t r;
    data_t  t;
    r = a;
    for (int i = 0; i < 7; i++)
      for (int j = i + 1; j < 8; j++)
        if (r[j] < r[i]) begin
          t = r[i]; r[i] = r[j]; r[j] = t;
        end
    return r;
  endfunction

  function automatic frame_t mk(input data_t a0, a1, a2, a3, a4, a5, a6, a7);
    frame_t f;
    f[0] = a0; f[1] = a1; f[2] = a2; f[3] = a3;
    f[4] = a4; f[5] = a5; f[6] = a6; f[7] = a7;
    return f;
  endfunction

  // Sorter stand-in: registered read port, optional stale ready after start, then a busy window.
  frame_t mem;
  int     s_ph;
  int     s_cnt;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_ready <= 1'b1;
      s_dout  <= '0;
      s_ph    <= 0;
      s_cnt   <= 0;
    end else begin
      s_dout <= mem[w_srt_addr];
      if (w_srt_wr) mem[w_srt_addr] <= w_srt_datain;
      case (s_ph)
        0: if (w_srt_start) begin s_ph <= 1; s_cnt <= s_stale; end
        1: if (s_cnt == 0) begin s_ready <= 1'b0; s_ph <= 2; s_cnt <= s_busy_len; end
           else s_cnt <= s_cnt - 1;
        default: if (s_cnt == 0) begin mem <= sort8(mem); s_ready <= 1'b1; s_ph <= 0; end
           else s_cnt <= s_cnt - 1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor state.
  logic  m_pv, m_pr, m_pl, m_after_last, m_low_seen;
  data_t m_pd;
  addr_t m_wr_idx;
  int    m_starts = 0;
  int    m_pops   = 0;

  task automatic monitor_step();
    exp_t e;
    if (!nrst) begin
      m_pv = 1'b0; m_pr = 1'b0; m_after_last = 1'b0; m_low_seen = 1'b0; m_wr_idx = '0;
      return;
    end
    if (m_after_last) begin
      chk("in_ready_after_last", 32'(bus.in_ready), 1);
      chk("busy_after_last", 32'(w_busy), 0);
    end
    if (m_pv && !m_pr) begin
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_data", 32'(bus.out_data), 32'(m_pd));
      chk("hold_last", 32'(bus.out_last), 32'(m_pl));
    end
    if (bus.in_valid && bus.in_ready) begin
      chk("wr_en", 32'(w_srt_wr), 1);
      chk("wr_addr", 32'(w_srt_addr), 32'(m_wr_idx));
      chk("wr_data", 32'(w_srt_datain), 32'(bus.in_data));
      m_wr_idx++;
    end else begin
      chk("no_stray_wr", 32'(w_srt_wr), 0);
      chk("datain_idle", 32'(w_srt_datain), 0);
    end
    if (w_srt_start) begin
      m_starts++;
      m_low_seen = 1'b0;
    end else if (!s_ready) begin
      m_low_seen = 1'b1;
    end
    if (bus.out_valid && !m_pv) chk("valid_after_sorter_busy", 32'(m_low_seen), 1);
    if (bus.out_valid) chk("in_ready_low_unloading", 32'(bus.in_ready), 0);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'(bus.out_data), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("out_last", 32'(bus.out_last), 32'(e.l));
        m_pops++;
      end
    end
    m_after_last = bus.out_valid && bus.out_ready && bus.out_last;
    m_pv = bus.out_valid;
    m_pr = bus.out_ready;
    m_pd = bus.out_data;
    m_pl = bus.out_last;
  endtask

  always @(negedge clk) monitor_step();

  task automatic send_byte(input data_t d, input int gmax);
    int   g;
    int   n;
    logic acc;
    bus.in_valid = 1'b0;
    g = int'($urandom_range(0, gmax));
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 4000) begin
      @(negedge clk);
      acc = bus.in_ready;
      n++;
    end
    if (!acc) chk("in_accept_timeout", 32'(acc), 1);
    else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t din, input frame_t dexp, input int gmax);
    for (int i = 0; i < 8; i++) q.push_back('{d: dexp[i], l: (i == 7)});
    for (int i = 0; i < 8; i++) send_byte(din[i], gmax);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_busy", 32'(w_busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_srt_wr", 32'(w_srt_wr), 0);
    chk("rst_srt_start", 32'(w_srt_start), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  initial begin
    int s0;
    int p0;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    fork
      forever begin
        @(posedge clk);
        #1 bus.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    reset_pulse();

    // Mixed values, continuous input.
    s0 = m_starts;
    send_frame(mk(8'd5, 8'd3, 8'd7, 8'd0, 8'd255, 8'd1, 8'd1, 8'd4),
               mk(8'd0, 8'd1, 8'd1, 8'd3, 8'd4, 8'd5, 8'd7, 8'd255), 0);
    drain();
    chk("start_pulses_f1", 32'(m_starts - s0), 1);

    // Sorted then reversed, back-to-back.
    s0 = m_starts;
    send_frame(mk(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7),
               mk(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7), 0);
    send_frame(mk(8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0),
               mk(8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7), 0);
    drain();
    chk("start_pulses_b2b", 32'(m_starts - s0), 2);

    // Input gaps and random backpressure.
    rnd_mode = 1'b1;
    s0 = m_starts;
    send_frame(mk(8'd9, 8'd9, 8'd9, 8'd2, 8'd2, 8'd8, 8'd0, 8'd8),
               mk(8'd0, 8'd2, 8'd2, 8'd8, 8'd8, 8'd9, 8'd9, 8'd9), 3);
    drain();
    rnd_mode = 1'b0;
    chk("start_pulses_rnd", 32'(m_starts - s0), 1);

    // Sorter keeps ready high for a while after start.
    s_stale = 2;
    send_frame(mk(8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1),
               mk(8'd1, 8'd3, 8'd6, 8'd12, 8'd25, 8'd50, 8'd100, 8'd200), 0);
    drain();
    s_stale = 0;

    // Reset while waiting on the sorter.
    s_busy_len = 30;
    send_frame(mk(8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4),
               mk(8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4), 0);
    n = 0;
    while (!(w_busy && !s_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait", 32'(w_busy && !s_ready), 1);
    reset_pulse();
    s_busy_len = 4;

    // Reset after three outputs of a frame.
    send_frame(mk(8'd30, 8'd20, 8'd10, 8'd60, 8'd50, 8'd40, 8'd80, 8'd70),
               mk(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80), 0);
    p0 = m_pops;
    n  = 0;
    while (m_pops < p0 + 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("three_outputs", 32'(m_pops - p0), 3);
    reset_pulse();

    // Fresh frame after reset.
    s0 = m_starts;
    send_frame(mk(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1),
               mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), 0);
    drain();
    chk("start_pulses_post_rst", 32'(m_starts - s0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sort_stream_adapter.md
Name: sort_stream_adapter

Overview:
- Stream front/back end for the 8-entry selection-sort engine (8-bit data, 3-bit address, start/ready host port).
- Accepts a frame of 8 bytes on a valid/ready input stream and writes them into the sorter through its host port.
- Pulses the sorter's start, waits for completion, then reads the sorted bytes out, lowest address first, onto a valid/ready output stream with a last flag.
- Sits directly upstream and downstream of the sorter; the sorter's host port is driven only by this block.

Parameters:
- WIDTH, 8, data width; must equal the sorter's data width.
- DEPTH, 8, elements per frame; fixed to the sorter's RAM depth.
- AW, 3, address width, $clog2(DEPTH).

Ports:
- clk  input  1  clock
- nrst  input  1  reset, asynchronous, active-low
- in_valid  input  1  input byte valid
- in_ready  output  1  adapter accepts input byte
- in_data  input  WIDTH  input byte
- out_valid  output  1  sorted byte valid
- out_ready  input  1  downstream accepts sorted byte
- out_data  output  WIDTH  sorted byte
- out_last  output  1  marks the 8th (largest) byte of a frame
- busy  output  1  high in every state except LOAD
- srt_datain  output  WIDTH  sorter host write data
- srt_addr  output  AW  sorter host address (write and read)
- srt_wr  output  1  sorter host write enable
- srt_start  output  1  sorter start pulse
- srt_ready  input  1  sorter idle flag
- srt_dataout  input  WIDTH  sorter read data, registered: valid the cycle after srt_addr is presented

Behaviour:
- Reset (nrst low, async): state LOAD, cnt=0, rd_pend=0, seen_busy=0.
  - Output values: out_valid=0, out_last=0, out_data=0, srt_wr=0, srt_start=0, busy=0.
  - in_ready = (state==LOAD). Upstream must not drive in_valid during reset.
- State machine: LOAD -> START -> WAIT -> UNLOAD -> LOAD.
- LOAD:
  - in_ready=1. The same cycle as in_valid&&in_ready: srt_wr=1, srt_addr=cnt, srt_datain=in_data; cnt increments (3-bit, wraps 7->0).
  - Accepting element with cnt==7 -> START, cnt=0.
  - in_valid gaps allowed; no timeout.
- START:
  - in_ready=0. srt_start=1 only when srt_ready==1, exactly one cycle, then -> WAIT.
  - If srt_ready==0, stay in START with srt_start=0.
  - srt_start is asserted no earlier than one cycle after the final write.
- WAIT:
  - seen_busy is set when srt_ready==0 is observed.
  - -> UNLOAD on the first cycle with seen_busy==1 && srt_ready==1; clear seen_busy on that transition.
  - A stale ready=1 in the first WAIT cycle never ends WAIT.
- UNLOAD:
  - Read issue rule: issue when !rd_pend && (!out_valid || out_ready) && reads_left.
    - On issue: srt_addr=cnt, rd_pend<=1, cnt++.
  - Next cycle: out_data<=srt_dataout, out_valid<=1, out_last<=(element index==7), rd_pend<=0.
  - out_valid, out_data and out_last are held stable until out_ready.
  - Throughput is 1 element per 2 cycles with out_ready held high; no faster behaviour is required.
  - Handshake with out_last=1 -> LOAD, cnt=0, out_valid=0, out_last=0.
- srt_wr=0 and srt_datain=0 outside LOAD writes. srt_addr=cnt in LOAD/UNLOAD, 0 otherwise.
- busy = (state != LOAD).
- Simultaneous events:
  - An accepted output and a new issue in the same cycle are legal.
  - No input is accepted until the frame's last output is accepted.
  - out_valid never depends combinationally on out_ready.
- Reset mid-operation: immediate return to LOAD; the partial frame is discarded. The sorter shares nrst and returns to its idle state. RAM contents are undefined until the next full load.
- The frame size is fixed at 8; there is no in_last input.

Decomposition:
- Shared package sort_pkg:
  - WIDTH/DEPTH/AW constants.
  - typedef enum logic [2:0] adapter_state_t {LOAD, START, WAIT, UNLOAD}.
  - typedefs data_t and addr_t.
- One sub-module is natural: sort_out_reg, the output holding register with rd_pend/capture logic and the valid/ready hold. The FSM and counters stay in the top module.

Test Plan:
- Load 5,3,7,0,255,1,1,4 with in_valid continuous and out_ready=1 -> out 0,1,1,3,4,5,7,255; out_last only on 255; exactly one srt_start pulse; in_ready=0 from START until after last output.
- Already sorted 0..7, then reverse 7..0, back-to-back frames -> both emit 0..7. in_ready re-asserts the cycle after the handshake on 7 (out_last=1).
- Random in_valid gaps plus random out_ready (about 50%) on 9,9,9,2,2,8,0,8 -> out 0,2,2,8,8,9,9,9. out_data/out_last stable while out_valid&&!out_ready; no duplicates or drops.
- Sorter model holds srt_ready=1 for 2 cycles after start -> adapter stays in WAIT; first out_valid only after srt_ready goes 0 then 1.
- nrst pulsed low during WAIT, and again mid-UNLOAD after 3 outputs -> out_valid=0, busy=0, in_ready=1 immediately. A fresh frame 1..8 reversed then sorts to 1..8.
- Write timing: for each accepted input, srt_wr=1 with srt_addr equal to the index 0..7 in the same cycle; no srt_wr outside LOAD.
